multicycle_ctrl_g7: RTL and testbench

//  Multi-cycle sequencer for the g7 RISC-V core: one instruction over several clocks on a shared ALU and a single memory port.

---
 rtl/multicycle_ctrl_g7.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl_g7.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_g7.sv
// Multi-cycle control sequencer for the g7 RISC-V core: Moore FSM that steps
// one instruction through fetch/decode/execute/memory/writeback on a shared ALU.
module multicycle_ctrl_g7 #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_ERROR    = 4'd15
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_instret;

    logic w_memState;
    logic w_timeout;
    logic w_retire;

    assign w_memState = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // A ready arriving on the last allowed wait cycle still completes the access.
    assign w_timeout  = (MEM_WAIT_MAX != 0) && w_memState && !mem_ready && (r_wait == WAIT_LAST);
    assign w_retire   = (r_state == S_WB_ALU) || (r_state == S_WB_MEM) || (r_state == S_BRANCH) ||
                        ((r_state == S_MEM_WR) && mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RST;
            r_wait    <= '0;
            r_instret <= '0;
        end else begin
            if (w_memState && !mem_ready && !w_timeout)
                r_wait <= r_wait + WAIT_W'(1);
            else
                r_wait <= '0;

            if (w_retire)
                r_instret <= r_instret + CNT_W'(1);

            case (r_state)
                S_RST:      r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready)      r_state <= S_DECODE;
                    else if (w_timeout) r_state <= S_ERROR;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_R:               r_state <= S_EXEC_R;
                        OP_ADDI:            r_state <= S_EXEC_I;
                        OP_LOAD, OP_STORE:  r_state <= S_MEM_ADDR;
                        OP_BRANCH:          r_state <= S_BRANCH;
                        default:            r_state <= S_ERROR;
                    endcase
                end
                S_EXEC_R, S_EXEC_I: r_state <= S_WB_ALU;
                S_MEM_ADDR: r_state <= (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (mem_ready)      r_state <= S_WB_MEM;
                    else if (w_timeout) r_state <= S_ERROR;
                end
                S_MEM_WR: begin
                    if (mem_ready)      r_state <= S_FETCH;
                    else if (w_timeout) r_state <= S_ERROR;
                end
                S_WB_ALU, S_WB_MEM, S_BRANCH: r_state <= S_FETCH;
                S_ERROR:    r_state <= S_ERROR;
                default:    r_state <= S_ERROR;
            endcase
        end
    end

    // Control word is a pure function of state, except the handshake-gated PC/IR loads.
    always_comb begin
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b10;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_WB_ALU:   reg_write = 1'b1;
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_en     = zero;
            end
            S_ERROR:    halted = 1'b1;
            default: ;
        endcase
    end

    assign state   = r_state;
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl_g7.sv
// Scoreboard bench for multicycle_ctrl_g7: directed per-cycle vectors push expected
// state/control/instret; a negedge monitor pops and compares against the DUT.
module tb_multicycle_ctrl_g7;

    localparam int CNT_W = 3;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    // {pc_en,pc_src,ir_write,iord,mem_read,mem_write,reg_write,mem_to_reg,alu_src_a,alu_src_b,alu_op,halted}
    localparam logic [13:0] C_ZERO = 14'b0_0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [13:0] C_FW   = 14'b0_0_0_0_1_0_0_0_0_01_00_0;
    localparam logic [13:0] C_FGO  = 14'b1_0_1_0_1_0_0_0_0_01_00_0;
    localparam logic [13:0] C_DEC  = 14'b0_0_0_0_0_0_0_0_0_10_00_0;
    localparam logic [13:0] C_EXR  = 14'b0_0_0_0_0_0_0_0_1_00_10_0;
    localparam logic [13:0] C_EXI  = 14'b0_0_0_0_0_0_0_0_1_10_00_0;
    localparam logic [13:0] C_MA   = 14'b0_0_0_0_0_0_0_0_1_10_00_0;
    localparam logic [13:0] C_MRD  = 14'b0_0_0_1_1_0_0_0_0_00_00_0;
    localparam logic [13:0] C_MWR  = 14'b0_0_0_1_0_1_0_0_0_00_00_0;
    localparam logic [13:0] C_WBA  = 14'b0_0_0_0_0_0_1_0_0_00_00_0;
    localparam logic [13:0] C_WBM  = 14'b0_0_0_0_0_0_1_1_0_00_00_0;
    localparam logic [13:0] C_BRT  = 14'b1_1_0_0_0_0_0_0_1_00_01_0;
    localparam logic [13:0] C_BRN  = 14'b0_1_0_0_0_0_0_0_1_00_01_0;
    localparam logic [13:0] C_ERR  = 14'b0_0_0_0_0_0_0_0_0_00_00_1;

    typedef struct packed {
        logic [3:0]       st;
        logic [13:0]      ctrl;
        logic [CNT_W-1:0] ret;
    } expected_t;

    logic clk = 1'b0;
    logic rst, zero, mem_ready;
    logic [6:0] opcode;
    logic pc_en, pc_src, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg, alu_src_a, halted;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;
    logic [CNT_W-1:0] instret;
    logic [13:0] actCtrl;

    expected_t expQ[$];
    int assertCount = 0;
    int failCount   = 0;

    multicycle_ctrl_g7 #(.MEM_WAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .halted(halted), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    assign actCtrl = {pc_en, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
                      mem_to_reg, alu_src_a, alu_src_b, alu_op, halted};

    // Drive one cycle's inputs just after the rising edge and queue what that cycle must show.
    task automatic applyStimulus(input logic r, input logic [6:0] op, input logic z, input logic rdy,
                                 input logic [3:0] st, input logic [13:0] ctrl, input int ret);
        expected_t e;
        @(posedge clk);
        #1;
        rst       = r;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        e.st   = st;
        e.ctrl = ctrl;
        e.ret  = CNT_W'(ret);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input expected_t e);
        assertCount++;
        if (state !== e.st) begin
            failCount++;
            $display("[TB] FAIL state at %0t: got %0d expected %0d", $time, state, e.st);
        end
        assertCount++;
        if (actCtrl !== e.ctrl) begin
            failCount++;
            $display("[TB] FAIL ctrl at %0t (state %0d): got %b expected %b", $time, e.st, actCtrl, e.ctrl);
        end
        assertCount++;
        if (instret !== e.ret) begin
            failCount++;
            $display("[TB] FAIL instret at %0t: got %0d expected %0d", $time, instret, e.ret);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0)
            checkOutput(expQ.pop_front());
    end

    initial begin
        rst = 1'b1; opcode = OP_ADDI; zero = 1'b0; mem_ready = 1'b0;

        applyStimulus(1, OP_ADDI, 0, 0, 0, C_ZERO, 0);
        applyStimulus(1, OP_ADDI, 0, 0, 0, C_ZERO, 0);
        applyStimulus(0, OP_ADDI, 0, 1, 0, C_ZERO, 0);

        // ADDI, immediate ready: 1,2,4,8
        applyStimulus(0, OP_ADDI, 0, 1, 1, C_FGO, 0);
        applyStimulus(0, OP_ADDI, 0, 0, 2, C_DEC, 0);
        applyStimulus(0, OP_ADDI, 0, 0, 4, C_EXI, 0);
        applyStimulus(0, OP_ADDI, 0, 0, 8, C_WBA, 0);

        // R-type
        applyStimulus(0, OP_R, 0, 1, 1, C_FGO, 1);
        applyStimulus(0, OP_R, 0, 0, 2, C_DEC, 1);
        applyStimulus(0, OP_R, 0, 0, 3, C_EXR, 1);
        applyStimulus(0, OP_R, 0, 0, 8, C_WBA, 1);

        // LOAD, ready on the 4th MEM_RD cycle (also the last allowed wait cycle)
        applyStimulus(0, OP_LOAD, 0, 1, 1, C_FGO, 2);
        applyStimulus(0, OP_LOAD, 0, 0, 2, C_DEC, 2);
        applyStimulus(0, OP_LOAD, 0, 0, 5, C_MA, 2);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, OP_LOAD, 0, 0, 6, C_MRD, 2);
        applyStimulus(0, OP_LOAD, 0, 1, 6, C_MRD, 2);
        applyStimulus(0, OP_LOAD, 0, 0, 9, C_WBM, 2);

        // STORE
        applyStimulus(0, OP_STOR, 0, 1, 1, C_FGO, 3);
        applyStimulus(0, OP_STOR, 0, 0, 2, C_DEC, 3);
        applyStimulus(0, OP_STOR, 0, 0, 5, C_MA, 3);
        applyStimulus(0, OP_STOR, 0, 1, 7, C_MWR, 3);

        // BEQ taken then not taken
        applyStimulus(0, OP_BEQ, 0, 1, 1, C_FGO, 4);
        applyStimulus(0, OP_BEQ, 0, 0, 2, C_DEC, 4);
        applyStimulus(0, OP_BEQ, 1, 0, 10, C_BRT, 4);
        applyStimulus(0, OP_BEQ, 0, 1, 1, C_FGO, 5);
        applyStimulus(0, OP_BEQ, 0, 0, 2, C_DEC, 5);
        applyStimulus(0, OP_BEQ, 0, 0, 10, C_BRN, 5);

        // Fetch ready on the 4th wait cycle
        for (int i = 0; i < 3; i++)
            applyStimulus(0, OP_ADDI, 0, 0, 1, C_FW, 6);
        applyStimulus(0, OP_ADDI, 0, 1, 1, C_FGO, 6);
        applyStimulus(0, OP_ADDI, 0, 0, 2, C_DEC, 6);
        applyStimulus(0, OP_ADDI, 0, 0, 4, C_EXI, 6);
        applyStimulus(0, OP_ADDI, 0, 0, 8, C_WBA, 6);

        // R-type retiring 7 -> 0 (counter wrap), then BEQ -> 1
        applyStimulus(0, OP_R, 0, 1, 1, C_FGO, 7);
        applyStimulus(0, OP_R, 0, 0, 2, C_DEC, 7);
        applyStimulus(0, OP_R, 0, 0, 3, C_EXR, 7);
        applyStimulus(0, OP_R, 0, 0, 8, C_WBA, 7);
        applyStimulus(0, OP_BEQ, 0, 1, 1, C_FGO, 0);
        applyStimulus(0, OP_BEQ, 0, 0, 2, C_DEC, 0);
        applyStimulus(0, OP_BEQ, 1, 0, 10, C_BRT, 0);

        // Fetch timeout after 4 wait cycles; ERROR is sticky and instret frozen
        for (int i = 0; i < 4; i++)
            applyStimulus(0, OP_ADDI, 0, 0, 1, C_FW, 1);
        applyStimulus(0, OP_ADDI, 1, 1, 15, C_ERR, 1);
        applyStimulus(0, OP_ADDI, 1, 1, 15, C_ERR, 1);

        // Reset out of ERROR, retire one ADDI, then reset in the middle of a MEM_RD wait
        applyStimulus(1, OP_ADDI, 0, 0, 0, C_ZERO, 0);
        applyStimulus(0, OP_ADDI, 0, 1, 0, C_ZERO, 0);
        applyStimulus(0, OP_ADDI, 0, 1, 1, C_FGO, 0);
        applyStimulus(0, OP_ADDI, 0, 0, 2, C_DEC, 0);
        applyStimulus(0, OP_ADDI, 0, 0, 4, C_EXI, 0);
        applyStimulus(0, OP_ADDI, 0, 0, 8, C_WBA, 0);
        applyStimulus(0, OP_LOAD, 0, 1, 1, C_FGO, 1);
        applyStimulus(0, OP_LOAD, 0, 0, 2, C_DEC, 1);
        applyStimulus(0, OP_LOAD, 0, 0, 5, C_MA, 1);
        applyStimulus(0, OP_LOAD, 0, 0, 6, C_MRD, 1);
        applyStimulus(0, OP_LOAD, 0, 0, 6, C_MRD, 1);
        applyStimulus(1, OP_LOAD, 0, 0, 0, C_ZERO, 0);
        applyStimulus(0, OP_BAD, 0, 1, 0, C_ZERO, 0);

        // Illegal opcode at DECODE -> ERROR until reset
        applyStimulus(0, OP_BAD, 0, 1, 1, C_FGO, 0);
        applyStimulus(0, OP_BAD, 0, 0, 2, C_DEC, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, OP_BAD, 1, 1, 15, C_ERR, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
